// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scans NDIG snapshotted segment patterns onto one common-anode 7-seg bank
//   clk, rst        clock, synchronous active-high reset
//   en              scan enable; low forces dark display and rewinds the scan
//   digits_in       NDIG active-high {dp,g,f,e,d,c,b,a} patterns, digit k at [8k+7:8k]
//   seg_n, an_n     active-low segment / anode drive, at most one anode low
//   frame_done      pulse on the last cycle of each frame
module seg_scan_driver #(
    parameter int NDIG      = 4,
    parameter int DIV       = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NDIG*8-1:0]   digits_in,
    output logic [7:0]          seg_n,
    output logic [NDIG-1:0]     an_n,
    output logic                frame_done
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NDIG);
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
    state_t              state;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [NDIG*8-1:0]   snap;
    logic                slot_end, last, drive;
    assign slot_end = cnt == CW'(DIV - 1);
    assign last     = idx == IW'(NDIG - 1);
    assign drive    = state == DRIVE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            snap  <= '0;
        end else if (!en) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else if (state == IDLE) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
            snap  <= digits_in;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (state == BLANK && cnt == CW'(BLANK_CYC - 1))
                state <= DRIVE;
            if (drive && slot_end) begin
                state <= BLANK;
                idx   <= last ? '0 : idx + 1'b1;
                // frame boundary: take the next snapshot so a shifting chain never tears
                if (last)
                    snap <= digits_in;
            end
        end
    end
    always_comb begin
        seg_n      = drive ? ~snap[8*idx +: 8] : 8'hFF;
        an_n       = drive ? ~(NDIG'(1) << idx) : '1;
        frame_done = drive && last && slot_end;
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver (NDIG=4, DIV=8, BLANK_CYC=2)
module tb_seg_scan_driver;
    logic        clk = 0;
    logic        rst, en;
    logic [31:0] digits_in;
    logic [7:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_done;
    int          total = 0, bad = 0;
    logic [12:0] got, exp;
    logic [12:0] q[$];
    logic [7:0]  seg_tab [4] = '{8'hB0, 8'hA4, 8'hF9, 8'hC0};
    seg_scan_driver #(.NDIG(4), .DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst(rst), .en(en), .digits_in(digits_in),
        .seg_n(seg_n), .an_n(an_n), .frame_done(frame_done)
    );
    always #5 clk = ~clk;
    logic        run = 0;
    int          pos = 0;
    logic [31:0] msnap = 0;
    always @(posedge clk) begin : model
        logic        r;
        int          p;
        int          d;
        logic [31:0] s;
        logic        lit;
        r = run;
        p = pos;
        s = msnap;
        if (rst) begin
            r = 0;
            p = 0;
            s = 0;
        end else if (!en) begin
            r = 0;
            p = 0;
        end else if (!r) begin
            r = 1;
            p = 0;
            s = digits_in;
        end else if (p == 31) begin
            p = 0;
            s = digits_in;
        end else begin
            p++;
        end
        lit = r && (p % 8) >= 2;
        d   = p / 8;
        q.push_back(lit ? {~s[8*d +: 8], ~(4'b1 << d), p == 31} : {8'hFF, 4'hF, 1'b0});
        run   <= r;
        pos   <= p;
        msnap <= s;
    end
    task automatic cyc();
        @(negedge clk);
        got = {seg_n, an_n, frame_done};
        exp = q.size() != 0 ? q.pop_front() : 13'h0;
    endtask
    task automatic test_reset();
        rst = 1;
        en = 1;
        digits_in = 32'h3F06_5B4F;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            total += 2;
            if (got !== exp) begin bad++; $display("FAIL reset_sb c%0d: got %h want %h", c, got, exp); end
            if (got !== {8'hFF, 4'hF, 1'b0}) begin bad++; $display("FAIL reset_dark c%0d: got %h want %h", c, got, {8'hFF, 4'hF, 1'b0}); end
        end
        rst = 0;
    endtask
    task automatic test_scan();
        int s, w, fds;
        logic [12:0] want;
        fds = 0;
        for (int c = 1; c <= 64; c++) begin
            cyc();
            s = ((c - 1) / 8) % 4;
            w = (c - 1) % 8;
            want = w >= 2 ? {seg_tab[s], ~(4'b1 << s), c % 32 == 0} : {8'hFF, 4'hF, 1'b0};
            fds += int'(frame_done);
            total += 2;
            if (got !== exp) begin bad++; $display("FAIL scan_sb c%0d: got %h want %h", c, got, exp); end
            if (got !== want) begin bad++; $display("FAIL scan_tab c%0d: got %h want %h", c, got, want); end
        end
        total++;
        if (fds != 2) begin bad++; $display("FAIL scan_fd_count: got %0d want 2", fds); end
    endtask
    task automatic test_midframe_change();
        int s, w;
        logic [12:0] want;
        for (int c = 1; c <= 64; c++) begin
            cyc();
            s = ((c - 1) / 8) % 4;
            w = (c - 1) % 8;
            want = w < 2 ? {8'hFF, 4'hF, 1'b0} : {c <= 32 ? seg_tab[s] : 8'h00, ~(4'b1 << s), c % 32 == 0};
            total += 2;
            if (got !== exp) begin bad++; $display("FAIL mid_sb c%0d: got %h want %h", c, got, exp); end
            if (got !== want) begin bad++; $display("FAIL mid_tab c%0d: got %h want %h", c, got, want); end
            if (c == 10)
                digits_in = 32'hFFFF_FFFF;
        end
    endtask
    task automatic test_en_drop();
        for (int c = 1; c <= 34; c++) begin
            cyc();
            total++;
            if (got !== exp) begin bad++; $display("FAIL endrop_sb c%0d: got %h want %h", c, got, exp); end
            if ((c >= 21 && c <= 25) || c == 26) begin
                total++;
                if (got !== (c == 26 ? {8'h87, 4'hE, 1'b0} : {8'hFF, 4'hF, 1'b0})) begin
                    bad++;
                    $display("FAIL endrop c%0d: got %h want %h", c, got, c == 26 ? {8'h87, 4'hE, 1'b0} : {8'hFF, 4'hF, 1'b0});
                end
            end
            if (c == 20) begin
                en = 0;
                digits_in = 32'h1234_5678;
            end
            if (c == 23)
                en = 1;
        end
    endtask
    task automatic test_rst_mid();
        for (int c = 1; c <= 50; c++) begin
            cyc();
            total++;
            if (got !== exp) begin bad++; $display("FAIL rstmid_sb c%0d: got %h want %h", c, got, exp); end
            if (c == 13 || c == 14 || c == 15 || c == 16) begin
                total++;
                if (got !== {8'hFF, 4'hF, 1'b0}) begin bad++; $display("FAIL rstmid_dark c%0d: got %h want %h", c, got, {8'hFF, 4'hF, 1'b0}); end
            end
            if (c == 14) begin
                total++;
                if (dut.snap !== 32'h0) begin bad++; $display("FAIL rstmid_snap: got %h want 0", dut.snap); end
            end
            if (c == 17) begin
                total++;
                if (got !== {8'h7E, 4'hE, 1'b0}) begin bad++; $display("FAIL rstmid_d0: got %h want %h", got, {8'h7E, 4'hE, 1'b0}); end
            end
            if (c == 25) begin
                total++;
                if (got !== {8'hF0, 4'hD, 1'b0}) begin bad++; $display("FAIL rstmid_d1: got %h want %h", got, {8'hF0, 4'hD, 1'b0}); end
            end
            if (c == 12)
                rst = 1;
            if (c == 13)
                digits_in = 32'hA5C3_0F81;
            if (c == 14)
                rst = 0;
        end
    endtask
    task automatic test_random();
        for (int c = 1; c <= 1000; c++) begin
            cyc();
            total += 3;
            if (got !== exp) begin bad++; $display("FAIL rand_sb c%0d: got %h want %h", c, got, exp); end
            if ($countones(~an_n) > 1) begin bad++; $display("FAIL rand_onehot c%0d: an_n %h want at most one zero", c, an_n); end
            if (an_n == 4'hF && seg_n !== 8'hFF) begin bad++; $display("FAIL rand_dark c%0d: seg_n %h want ff", c, seg_n); end
            en = $urandom_range(0, 15) != 0;
            rst = $urandom_range(0, 99) == 0;
            if ($urandom_range(0, 7) == 0)
                digits_in = $urandom;
        end
        rst = 0;
        en = 1;
    endtask
    initial begin
        test_reset();
        test_scan();
        test_midframe_change();
        test_en_drop();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
